// File: rtl/flex_down_timer_if.sv
// Control/status bundle for flex_down_timer: start/abort/pause commands,
// run configuration, and the registered timer status.
interface flex_down_timer_if #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
);
  logic                     start;
  logic                     abort;
  logic                     pause;
  logic                     periodic;
  logic [NUM_CNT_BITS-1:0]  load_val;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [NUM_CNT_BITS-1:0]  count_out;
  logic                     busy;
  logic                     expire_pulse;
  logic                     done;

  modport master (
    output start, abort, pause, periodic, load_val, prescale,
    input  count_out, busy, expire_pulse, done
  );

  modport slave (
    input  start, abort, pause, periodic, load_val, prescale,
    output count_out, busy, expire_pulse, done
  );
endinterface

// File: rtl/flex_down_timer.sv
// Loadable prescaled down-counter with one-shot/periodic expiry, used for
// bit-period and timeout generation in protocol control FSMs.
module flex_down_timer #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  flex_down_timer_if.slave tmr_if
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  state_t                   r_state, w_state_nx;
  logic [NUM_CNT_BITS-1:0]  r_count, w_count_nx;
  logic [PRESCALE_BITS-1:0] r_psc, w_psc_nx;
  logic [NUM_CNT_BITS-1:0]  r_cap_load, w_cap_load_nx;
  logic [PRESCALE_BITS-1:0] r_cap_psc, w_cap_psc_nx;
  logic                     r_cap_periodic, w_cap_periodic_nx;
  logic                     r_busy, w_busy_nx;
  logic                     r_expire, w_expire_nx;
  logic                     r_done, w_done_nx;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_psc          <= '0;
      r_cap_load     <= '0;
      r_cap_psc      <= '0;
      r_cap_periodic <= 1'b0;
      r_busy         <= 1'b0;
      r_expire       <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_count        <= w_count_nx;
      r_psc          <= w_psc_nx;
      r_cap_load     <= w_cap_load_nx;
      r_cap_psc      <= w_cap_psc_nx;
      r_cap_periodic <= w_cap_periodic_nx;
      r_busy         <= w_busy_nx;
      r_expire       <= w_expire_nx;
      r_done         <= w_done_nx;
    end
  end

  // Command priority is abort > start > pause > tick in both states.
  always_comb begin
    w_state_nx        = r_state;
    w_count_nx        = r_count;
    w_psc_nx          = r_psc;
    w_cap_load_nx     = r_cap_load;
    w_cap_psc_nx      = r_cap_psc;
    w_cap_periodic_nx = r_cap_periodic;
    w_expire_nx       = 1'b0;
    w_done_nx         = r_done;

    if (tmr_if.abort) begin
      if (r_state == RUN) begin
        w_state_nx = IDLE;
        w_count_nx = '0;
        w_psc_nx   = '0;
      end
    end else if (tmr_if.start) begin
      w_cap_load_nx     = tmr_if.load_val;
      w_cap_psc_nx      = tmr_if.prescale;
      w_cap_periodic_nx = tmr_if.periodic;
      w_psc_nx          = '0;
      if (tmr_if.load_val != '0) begin
        w_count_nx = tmr_if.load_val;
        w_state_nx = RUN;
        w_done_nx  = 1'b0;
      end else begin
        // A zero-length run expires on the start edge itself.
        w_count_nx  = '0;
        w_state_nx  = IDLE;
        w_expire_nx = 1'b1;
        w_done_nx   = 1'b1;
      end
    end else if ((r_state == RUN) && !tmr_if.pause) begin
      if (r_psc == r_cap_psc) begin
        w_psc_nx = '0;
        if (r_count <= CNT_ONE) begin
          w_expire_nx = 1'b1;
          if (r_cap_periodic) begin
            w_count_nx = r_cap_load;
          end else begin
            w_count_nx = '0;
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end
        end else begin
          w_count_nx = r_count - CNT_ONE;
        end
      end else begin
        w_psc_nx = r_psc + 1'b1;
      end
    end

    w_busy_nx = (w_state_nx == RUN);
  end

  assign tmr_if.count_out    = r_count;
  assign tmr_if.busy         = r_busy;
  assign tmr_if.expire_pulse = r_expire;
  assign tmr_if.done         = r_done;

endmodule

// File: tb/tb_flex_down_timer.sv
// Randomized and directed stimulus for flex_down_timer, scored each cycle
// against an elapsed-time reference model.
module tb_flex_down_timer;
  localparam int NB = 4;
  localparam int PB = 4;

  logic clk;
  logic n_rst;

  flex_down_timer_if #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) tif ();

  flex_down_timer #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .tmr_if (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a run is described by its length in unpaused cycles;
  // the count is derived from how many of those cycles have elapsed.
  bit m_run, m_per, m_done, m_pulse;
  int m_load, m_p1, m_elapsed;

  function automatic int m_count();
    return m_run ? (m_load - m_elapsed / m_p1) : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    m_pulse = 1'b0;
    if (!n_rst) begin
      m_run = 0; m_per = 0; m_done = 0; m_load = 0; m_p1 = 1; m_elapsed = 0;
    end else if (tif.abort) begin
      m_run = 0;
    end else if (tif.start) begin
      m_load = int'(tif.load_val); m_p1 = int'(tif.prescale) + 1;
      m_per = tif.periodic; m_elapsed = 0;
      if (m_load != 0) begin
        m_run = 1; m_done = 0;
      end else begin
        m_run = 0; m_pulse = 1; m_done = 1;
      end
    end else if (m_run && !tif.pause) begin
      m_elapsed++;
      if (m_elapsed == m_load * m_p1) begin
        m_pulse = 1;
        m_elapsed = 0;
        if (!m_per) begin
          m_run = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("count_out", int'(tif.count_out), m_count());
    chk("busy", int'(tif.busy), int'(m_run));
    chk("expire_pulse", int'(tif.expire_pulse), int'(m_pulse));
    chk("done", int'(tif.done), int'(m_done));
  endtask

  task automatic do_start(input int lv, input int ps, input bit per);
    tif.load_val = NB'(lv);
    tif.prescale = PB'(ps);
    tif.periodic = per;
    tif.start    = 1'b1;
    step();
    tif.start    = 1'b0;
  endtask

  // Steps until expire_pulse is seen; returns the number of steps taken,
  // or -1 if the budget ran out.
  task automatic wait_pulse(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (tif.expire_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  int n;

  initial begin
    n_rst = 1'b0;
    tif.start = 0; tif.abort = 0; tif.pause = 0; tif.periodic = 0;
    tif.load_val = '0; tif.prescale = '0;
    step(); step();
    chk("reset_count", int'(tif.count_out), 0);
    chk("reset_busy", int'(tif.busy), 0);
    n_rst = 1'b1;
    step();

    // Reset mid-run
    do_start(5, 0, 0);
    step(); step();
    n_rst = 1'b0;
    step();
    chk("midrun_reset_count", int'(tif.count_out), 0);
    chk("midrun_reset_busy", int'(tif.busy), 0);
    n_rst = 1'b1;
    step();

    // One-shot, no prescale: count 3,2,1,0
    do_start(3, 0, 0);
    chk("oneshot_e0", int'(tif.count_out), 3);
    step(); chk("oneshot_e1", int'(tif.count_out), 2);
    step(); chk("oneshot_e2", int'(tif.count_out), 1);
    step(); chk("oneshot_e3", int'(tif.count_out), 0);
    chk("oneshot_pulse", int'(tif.expire_pulse), 1);
    chk("oneshot_done", int'(tif.done), 1);
    chk("oneshot_busy", int'(tif.busy), 0);
    step();

    // Prescale with a 4-cycle pause
    do_start(2, 2, 0);
    step(); step();
    tif.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pause_hold", int'(tif.count_out), 2);
    end
    tif.pause = 1'b0;
    wait_pulse(50, n);
    chk("pause_latency", n + 6, 10);

    // Periodic reload
    do_start(4, 1, 1);
    wait_pulse(50, n);
    chk("periodic_first", n, 8);
    chk("periodic_reload", int'(tif.count_out), 4);
    wait_pulse(50, n);
    chk("periodic_interval", n, 8);
    chk("periodic_busy", int'(tif.busy), 1);
    tif.abort = 1'b1; step(); tif.abort = 1'b0;

    // Zero load, abort, restart
    do_start(0, 3, 0);
    chk("zero_pulse", int'(tif.expire_pulse), 1);
    chk("zero_done", int'(tif.done), 1);
    do_start(9, 1, 0);
    step(); step();
    tif.abort = 1'b1; step(); tif.abort = 1'b0;
    chk("abort_count", int'(tif.count_out), 0);
    chk("abort_pulse", int'(tif.expire_pulse), 0);
    do_start(6, 0, 0);
    step();
    do_start(7, 0, 0);
    chk("restart_count", int'(tif.count_out), 7);
    chk("restart_pulse", int'(tif.expire_pulse), 0);
    tif.abort = 1'b1; step(); tif.abort = 1'b0;

    // Max values
    do_start(15, 15, 0);
    wait_pulse(400, n);
    chk("max_latency", n, 240);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tif.start    = ($urandom_range(15) == 0);
      tif.abort    = ($urandom_range(63) == 0);
      tif.pause    = ($urandom_range(7) == 0);
      tif.periodic = $urandom_range(1);
      tif.load_val = NB'($urandom_range(15));
      tif.prescale = ($urandom_range(3) == 0) ? PB'($urandom_range(15)) : PB'($urandom_range(2));
      n_rst        = ($urandom_range(299) != 0);
      step();
    end
    tif.start = 0; tif.abort = 0; tif.pause = 0; n_rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
